// File: rtl/ps2_key_tracker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_tracker_if                                                         |
// | PS/2 line inputs and key/byte/status outputs of the PS/2 key tracker.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ps2_key_tracker_if;
    logic        i_ps2_clk;
    logic        i_ps2_dat;
    logic [31:0] o_key;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        o_err;
    logic [2:0]  o_state;

    modport master (
        output i_ps2_clk, i_ps2_dat,
        input  o_key, o_byte, o_byte_valid, o_err, o_state
    );

    modport slave (
        input  i_ps2_clk, i_ps2_dat,
        output o_key, o_byte, o_byte_valid, o_err, o_state
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_tracker                                                            |
// | PS/2 keyboard receiver keeping a 32-bit held-key bitmap (make/F0/E0).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_key_tracker #(
    parameter int TIMEOUT = 200
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    ps2_key_tracker_if.slave   bus
);
    localparam int                c_tmo_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3
    } state_t;

    logic               r_clk_s1, r_clk_s2, r_clk_s3;
    logic               r_dat_s1, r_dat_s2;
    state_t             r_state, w_state_nxt;
    logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_parity, w_parity_nxt;
    logic [c_tmo_w-1:0] r_tmo_cnt, w_tmo_nxt;
    logic               w_fall, w_bit;
    logic               w_accept, w_frame_err, w_timeout;
    logic [5:0]         w_map;
    logic               r_ext, r_brk;
    logic [31:0]        r_key;
    logic [7:0]         r_byte;
    logic               r_byte_valid, r_err;

    // Returns {hit, bit index} for the set-2 codes tracked in the bitmap.
    function automatic logic [5:0] key_index(input logic [7:0] code);
        case (code)
            8'h1A: key_index = {1'b1, 5'd0};   8'h22: key_index = {1'b1, 5'd1};
            8'h21: key_index = {1'b1, 5'd2};   8'h2A: key_index = {1'b1, 5'd3};
            8'h32: key_index = {1'b1, 5'd4};   8'h31: key_index = {1'b1, 5'd5};
            8'h3A: key_index = {1'b1, 5'd6};   8'h41: key_index = {1'b1, 5'd7};
            8'h49: key_index = {1'b1, 5'd8};   8'h4A: key_index = {1'b1, 5'd9};
            8'h1C: key_index = {1'b1, 5'd10};  8'h1B: key_index = {1'b1, 5'd11};
            8'h23: key_index = {1'b1, 5'd12};  8'h2B: key_index = {1'b1, 5'd13};
            8'h34: key_index = {1'b1, 5'd14};  8'h33: key_index = {1'b1, 5'd15};
            8'h3B: key_index = {1'b1, 5'd16};  8'h42: key_index = {1'b1, 5'd17};
            8'h4B: key_index = {1'b1, 5'd18};  8'h4C: key_index = {1'b1, 5'd19};
            8'h52: key_index = {1'b1, 5'd20};  8'h15: key_index = {1'b1, 5'd21};
            8'h1D: key_index = {1'b1, 5'd22};  8'h24: key_index = {1'b1, 5'd23};
            8'h2D: key_index = {1'b1, 5'd24};  8'h2C: key_index = {1'b1, 5'd25};
            8'h35: key_index = {1'b1, 5'd26};  8'h3C: key_index = {1'b1, 5'd27};
            8'h43: key_index = {1'b1, 5'd28};  8'h44: key_index = {1'b1, 5'd29};
            8'h4D: key_index = {1'b1, 5'd30};  8'h54: key_index = {1'b1, 5'd31};
            default: key_index = 6'd0;
        endcase
    endfunction

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= bus.i_ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_s3 & ~r_clk_s2;
    assign w_bit  = r_dat_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_tmo_cnt <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_tmo_nxt     = '0;
        w_accept      = 1'b0;
        w_frame_err   = 1'b0;
        w_timeout     = 1'b0;

        if (r_state != S_IDLE && !w_fall && r_tmo_cnt != c_tmo_max)
            w_tmo_nxt = r_tmo_cnt + 1'b1;
        else if (r_state != S_IDLE && !w_fall)
            w_tmo_nxt = r_tmo_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_fall && !w_bit) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = 3'd0;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_nxt   = {w_bit, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7)
                        w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_parity_nxt = w_bit;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    if (w_bit && (^{r_shift, r_parity}))
                        w_accept = 1'b1;
                    else
                        w_frame_err = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (r_state != S_IDLE && !w_fall && r_tmo_cnt == c_tmo_max) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    assign w_map = key_index(r_shift);

    // Prefix flags persist across bytes until a non-prefix code consumes them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key        <= 32'd0;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
        end else begin
            r_byte_valid <= w_accept;
            r_err        <= w_frame_err | w_timeout;
            if (w_accept) begin
                r_byte <= r_shift;
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    if (!r_ext && w_map[5])
                        r_key[w_map[4:0]] <= ~r_brk;
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign bus.o_key        = r_key;
    assign bus.o_byte       = r_byte;
    assign bus.o_byte_valid = r_byte_valid;
    assign bus.o_err        = r_err;
    assign bus.o_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_key_tracker                                                         |
// | Scoreboard bench for the PS/2 key tracker.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_key_tracker;
    localparam int c_timeout = 200;

    typedef struct {
        bit          is_err;
        bit          is_tmo;
        logic [7:0]  b;
        logic [31:0] k;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   last_fall;
    int   n_valid;
    int   n_valid_exp;
    exp_t sb[$];

    logic [31:0] m_key;
    logic [7:0]  m_byte;
    bit          m_ext, m_brk;
    logic [7:0]  key_codes [32];

    ps2_key_tracker_if bus ();

    ps2_key_tracker #(.TIMEOUT(c_timeout)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: bitmap position found by searching the code table.
    task automatic model_accept(input logic [7:0] code);
        exp_t e;
        m_byte = code;
        if (code == 8'hE0) m_ext = 1'b1;
        else if (code == 8'hF0) m_brk = 1'b1;
        else begin
            if (!m_ext)
                for (int i = 0; i < 32; i++)
                    if (key_codes[i] == code) m_key[i] = ~m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        e.is_err = 1'b0; e.is_tmo = 1'b0; e.b = m_byte; e.k = m_key;
        sb.push_back(e);
        n_valid_exp++;
    endtask

    task automatic push_err(input bit tmo);
        exp_t e;
        e.is_err = 1'b1; e.is_tmo = tmo; e.b = m_byte; e.k = m_key;
        sb.push_back(e);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] code, input bit bad_par);
        logic par;
        par = (~^code) ^ bad_par;
        return {1'b1, par, code, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.i_ps2_dat = f[i];
            repeat (4) @(negedge clk);
            bus.i_ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (5) @(negedge clk);
            bus.i_ps2_clk = 1'b1;
        end
        @(negedge clk) bus.i_ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] code);
        model_accept(code);
        send_bits(mk_frame(code, 1'b0), 11);
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_key", bus.o_key, 32'd0);
        check_val("rst_state", {29'd0, bus.o_state}, 32'd0);
        check_val("rst_pulses", {30'd0, bus.o_byte_valid, bus.o_err}, 32'd0);
        rst_n = 1'b1;
        m_key = '0; m_byte = '0; m_ext = 1'b0; m_brk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.o_byte_valid || bus.o_err)) begin
            if (bus.o_byte_valid) n_valid++;
            if (bus.o_byte_valid && bus.o_err)
                check_val("pulse_excl", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                check_val("unexpected_pulse", {30'd0, bus.o_byte_valid, bus.o_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("pulse_kind", {31'd0, bus.o_err}, {31'd0, e.is_err});
                check_val("byte", {24'd0, bus.o_byte}, {24'd0, e.b});
                check_val("key", bus.o_key, e.k);
                if (e.is_tmo)
                    check_val("tmo_latency", cyc - last_fall, 3 + c_timeout + 1);
            end
        end
    end

    initial begin
        logic [7:0] tbl [32];
        tbl = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h41, 8'h49, 8'h4A,
                8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52,
                8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54};
        key_codes = tbl;
        n_checks = 0; n_fail = 0; cyc = 0; last_fall = 0;
        n_valid = 0; n_valid_exp = 0;
        m_key = '0; m_byte = '0; m_ext = 1'b0; m_brk = 1'b0;
        bus.i_ps2_clk = 1'b1;
        bus.i_ps2_dat = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();

        // Make, then second key, then break of the first.
        send_byte(8'h1C);
        check_val("make_1c", bus.o_key, 32'h0000_0400);
        send_byte(8'h15);
        check_val("make_15", bus.o_key, 32'h0020_0400);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_val("break_1c", bus.o_key, 32'h0020_0000);
        send_byte(8'h15);
        check_val("typematic", bus.o_key, 32'h0020_0000);

        // Bad parity: error pulse, nothing else changes.
        push_err(1'b0);
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        repeat (20) @(negedge clk);
        check_val("par_key", bus.o_key, 32'h0020_0000);
        check_val("par_byte", {24'd0, bus.o_byte}, 32'h15);

        // Extended and unmapped codes leave the bitmap alone.
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h76);
        check_val("ext_key", bus.o_key, 32'd0);
        send_byte(8'hF0);
        send_byte(8'h4A);
        check_val("brk_unheld", bus.o_key, 32'd0);
        send_byte(8'h1C);
        check_val("ext_clear", bus.o_key, 32'h0000_0400);

        // Truncated frame times out.
        do_reset();
        push_err(1'b1);
        send_bits(mk_frame(8'h1A, 1'b0), 5);
        repeat (250) @(negedge clk);
        check_val("tmo_state", {29'd0, bus.o_state}, 32'd0);
        send_byte(8'h1A);
        check_val("tmo_recover", bus.o_key, 32'h0000_0001);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h1A);
        check_val("held_two", bus.o_key, 32'h0000_0401);
        send_bits(mk_frame(8'h22, 1'b0), 4);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_key", bus.o_key, 32'd0);
        check_val("midrst_state", {29'd0, bus.o_state}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_key = '0; m_byte = '0; m_ext = 1'b0; m_brk = 1'b0;
        repeat (10) @(negedge clk);
        send_byte(8'h22);
        check_val("post_rst", bus.o_key, 32'h0000_0002);

        repeat (20) @(negedge clk);
        check_val("sb_empty", sb.size(), 32'd0);
        check_val("valid_count", n_valid, n_valid_exp);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
